// File: rtl/ctx_wrq_sink.sv
// Context-shadow write-request sink: buffers tracker write requests in a FIFO
// and retires each one to the 8-bit SRAM arbiter port as one or two byte writes.
module ctx_wrq_sink #(
    parameter int DEPTH = 8
) (
    input  logic                     clkin,
    input  logic                     reset_n,
    input  logic                     BUS_WRQ,
    input  logic [23:0]              ROM_ADDR,
    input  logic [15:0]              ROM_DATA,
    input  logic                     ROM_WORD_ENABLE,
    output logic                     BUS_RDY,
    output logic                     SRAM_REQ,
    output logic [23:0]              SRAM_ADDR,
    output logic [7:0]               SRAM_DATA,
    input  logic                     SRAM_ACK,
    input  logic                     OVF_CLR,
    output logic                     OVERFLOW,
    output logic [$clog2(DEPTH):0]   COUNT,
    output logic [1:0]               dbg_state
);

    localparam int AW = $clog2(DEPTH);

    // Handshake: a request is offered while SRAM_REQ = 1 with SRAM_ADDR/SRAM_DATA
    // held constant; it retires on any rising edge where SRAM_REQ & SRAM_ACK.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2
    } state_t;

    state_t          state, state_n;
    logic [40:0]     mem [DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic            empty, full, full_n;
    logic            pop, push, drop, ack_fire;
    logic [40:0]     head;
    logic            h_word;
    logic [23:0]     h_addr;
    logic [15:0]     h_data;
    logic            req_n;
    logic [23:0]     addr_n;
    logic [7:0]      data_n;

    // Extra wrap bit on each pointer separates full from empty.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign ack_fire = SRAM_REQ && SRAM_ACK;
    assign COUNT    = wr_ptr - rd_ptr;
    assign dbg_state = state;

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_n = S_LO;
                end
            end
            S_LO: begin
                if (ack_fire) begin
                    if (h_word) begin
                        state_n = S_HI;
                    end else if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_LO;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_HI: begin
                if (ack_fire) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_n = S_LO;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push     = BUS_WRQ && (!full || pop);
    assign drop     = BUS_WRQ && full && !pop;
    assign wr_ptr_n = wr_ptr + (AW + 1)'(push);
    assign rd_ptr_n = rd_ptr + (AW + 1)'(pop);
    assign full_n   = (wr_ptr_n[AW] != rd_ptr_n[AW]) &&
                      (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);

    always_comb begin
        req_n  = (state_n != S_IDLE);
        addr_n = SRAM_ADDR;
        data_n = SRAM_DATA;
        if (pop) begin
            addr_n = head[39:16];
            data_n = head[7:0];
        end else if (state == S_LO && state_n == S_HI) begin
            addr_n = h_addr + 24'd1;
            data_n = h_data[15:8];
        end
    end

    always_ff @(posedge clkin) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {ROM_WORD_ENABLE, ROM_ADDR, ROM_DATA};
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            h_word    <= 1'b0;
            h_addr    <= '0;
            h_data    <= '0;
            SRAM_REQ  <= 1'b0;
            SRAM_ADDR <= '0;
            SRAM_DATA <= '0;
            OVERFLOW  <= 1'b0;
            BUS_RDY   <= 1'b1;
        end else begin
            state     <= state_n;
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            SRAM_REQ  <= req_n;
            SRAM_ADDR <= addr_n;
            SRAM_DATA <= data_n;
            BUS_RDY   <= !full_n;
            if (pop) begin
                h_word <= head[40];
                h_addr <= head[39:16];
                h_data <= head[15:0];
            end
            if (drop) begin
                OVERFLOW <= 1'b1;
            end else if (OVF_CLR) begin
                OVERFLOW <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_ctx_wrq_sink.sv
// Self-checking bench for ctx_wrq_sink: directed scenarios plus a randomized run,
// with every retired SRAM byte compared against a queue of expected bytes.
module tb_ctx_wrq_sink;

    localparam int DEPTH = 8;

    logic        clkin = 1'b0;
    logic        reset_n;
    logic        BUS_WRQ;
    logic [23:0] ROM_ADDR;
    logic [15:0] ROM_DATA;
    logic        ROM_WORD_ENABLE;
    logic        BUS_RDY;
    logic        SRAM_REQ;
    logic [23:0] SRAM_ADDR;
    logic [7:0]  SRAM_DATA;
    logic        SRAM_ACK;
    logic        OVF_CLR;
    logic        OVERFLOW;
    logic [3:0]  COUNT;
    logic [1:0]  dbg_state;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    always #5 clkin = ~clkin;

    ctx_wrq_sink #(.DEPTH(DEPTH)) dut (
        .clkin(clkin),
        .reset_n(reset_n),
        .BUS_WRQ(BUS_WRQ),
        .ROM_ADDR(ROM_ADDR),
        .ROM_DATA(ROM_DATA),
        .ROM_WORD_ENABLE(ROM_WORD_ENABLE),
        .BUS_RDY(BUS_RDY),
        .SRAM_REQ(SRAM_REQ),
        .SRAM_ADDR(SRAM_ADDR),
        .SRAM_DATA(SRAM_DATA),
        .SRAM_ACK(SRAM_ACK),
        .OVF_CLR(OVF_CLR),
        .OVERFLOW(OVERFLOW),
        .COUNT(COUNT),
        .dbg_state(dbg_state)
    );

    // Scoreboard: retired bytes must match the expected stream in order, and an
    // offered byte must not change until it is acknowledged.
    logic        prev_req = 1'b0;
    logic        prev_ack = 1'b0;
    logic [23:0] prev_addr = '0;
    logic [7:0]  prev_data = '0;
    logic [31:0] exp_b;

    always @(posedge clkin) begin
        if (!reset_n) begin
            prev_req <= 1'b0;
            prev_ack <= 1'b0;
        end else begin
            if (prev_req && !prev_ack && SRAM_REQ) begin
                checks++;
                if (SRAM_ADDR !== prev_addr || SRAM_DATA !== prev_data) begin
                    failures++;
                    $display("FAIL stable: addr/data %h/%h changed from %h/%h before ack",
                             SRAM_ADDR, SRAM_DATA, prev_addr, prev_data);
                end
            end
            if (SRAM_REQ && SRAM_ACK) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL retire: unexpected byte %h/%h, none required", SRAM_ADDR, SRAM_DATA);
                end else begin
                    exp_b = exp_q.pop_front();
                    if ({SRAM_ADDR, SRAM_DATA} !== exp_b) begin
                        failures++;
                        $display("FAIL retire: got %h/%h required %h/%h",
                                 SRAM_ADDR, SRAM_DATA, exp_b[31:8], exp_b[7:0]);
                    end
                end
            end
            prev_req  <= SRAM_REQ;
            prev_ack  <= SRAM_ACK;
            prev_addr <= SRAM_ADDR;
            prev_data <= SRAM_DATA;
        end
    end

    task automatic tick;
        @(posedge clkin);
        #1;
    endtask

    // One-cycle request; accepted requests are expanded into little-endian bytes.
    task automatic push_req(input logic [23:0] a, input logic [15:0] d,
                            input logic word, input logic accepted);
        BUS_WRQ = 1'b1;
        ROM_ADDR = a;
        ROM_DATA = d;
        ROM_WORD_ENABLE = word;
        if (accepted) begin
            exp_q.push_back({a, d[7:0]});
            if (word) exp_q.push_back({a + 24'd1, d[15:8]});
        end
        tick();
        BUS_WRQ = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (!SRAM_REQ && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (!SRAM_REQ) begin
            failures++;
            $display("FAIL wait_req: SRAM_REQ=%b after %0d cycles, required 1", SRAM_REQ, n);
        end
    endtask

    task automatic drain;
        int n = 0;
        SRAM_ACK = 1'b1;
        while ((exp_q.size() != 0 || SRAM_REQ) && n < 300) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0 || SRAM_REQ) begin
            failures++;
            $display("FAIL drain: %0d bytes left, SRAM_REQ=%b, required 0/0", exp_q.size(), SRAM_REQ);
        end
    endtask

    task automatic do_reset;
        reset_n = 1'b0;
        BUS_WRQ = 1'b0;
        SRAM_ACK = 1'b0;
        OVF_CLR = 1'b0;
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b1;
        BUS_WRQ = 1'b0;
        ROM_ADDR = '0;
        ROM_DATA = '0;
        ROM_WORD_ENABLE = 1'b0;
        SRAM_ACK = 1'b0;
        OVF_CLR = 1'b0;
        #1 reset_n = 1'b0;
        #2;
        checks++;
        if (SRAM_REQ !== 1'b0 || SRAM_ADDR !== 24'h0 || SRAM_DATA !== 8'h0) begin
            failures++;
            $display("FAIL reset_sram: req/addr/data %b/%h/%h required 0/000000/00",
                     SRAM_REQ, SRAM_ADDR, SRAM_DATA);
        end
        checks++;
        if (OVERFLOW !== 1'b0 || COUNT !== 4'd0 || BUS_RDY !== 1'b1 || dbg_state !== 2'd0) begin
            failures++;
            $display("FAIL reset_status: ovf/count/rdy/state %b/%0d/%b/%0d required 0/0/1/0",
                     OVERFLOW, COUNT, BUS_RDY, dbg_state);
        end
        repeat (2) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single_byte;
        SRAM_ACK = 1'b1;
        push_req(24'hF90044, 16'h5A5A, 1'b0, 1'b1);
        checks++;
        if (COUNT !== 4'd1 || SRAM_REQ !== 1'b0) begin
            failures++;
            $display("FAIL single_c1: count/req %0d/%b required 1/0", COUNT, SRAM_REQ);
        end
        tick();
        checks++;
        if (SRAM_REQ !== 1'b1 || SRAM_ADDR !== 24'hF90044 || SRAM_DATA !== 8'h5A) begin
            failures++;
            $display("FAIL single_c2: req/addr/data %b/%h/%h required 1/f90044/5a",
                     SRAM_REQ, SRAM_ADDR, SRAM_DATA);
        end
        tick();
        checks++;
        if (SRAM_REQ !== 1'b0 || COUNT !== 4'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL single_done: req/count/left %b/%0d/%0d required 0/0/0",
                     SRAM_REQ, COUNT, exp_q.size());
        end
    endtask

    task automatic test_word_split;
        SRAM_ACK = 1'b0;
        push_req(24'hF9050A, 16'h1234, 1'b1, 1'b1);
        wait_req();
        checks++;
        if (SRAM_ADDR !== 24'hF9050A || SRAM_DATA !== 8'h34) begin
            failures++;
            $display("FAIL word_lo: addr/data %h/%h required f9050a/34", SRAM_ADDR, SRAM_DATA);
        end
        repeat (3) tick();
        SRAM_ACK = 1'b1;
        tick();
        SRAM_ACK = 1'b0;
        checks++;
        if (SRAM_REQ !== 1'b1 || SRAM_ADDR !== 24'hF9050B || SRAM_DATA !== 8'h12) begin
            failures++;
            $display("FAIL word_hi: req/addr/data %b/%h/%h required 1/f9050b/12",
                     SRAM_REQ, SRAM_ADDR, SRAM_DATA);
        end
        repeat (3) tick();
        SRAM_ACK = 1'b1;
        tick();
        SRAM_ACK = 1'b0;
        checks++;
        if (SRAM_REQ !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL word_done: req/left %b/%0d required 0/0", SRAM_REQ, exp_q.size());
        end
    endtask

    task automatic test_addr_wrap;
        SRAM_ACK = 1'b1;
        push_req(24'hFFFFFF, 16'hBEEF, 1'b1, 1'b1);
        drain();
    endtask

    // Leaves the FIFO full with one byte waiting on the SRAM port.
    task automatic test_overflow;
        SRAM_ACK = 1'b0;
        push_req(24'h100000, 16'h00F0, 1'b0, 1'b1);
        wait_req();
        for (int i = 0; i < DEPTH; i++) begin
            push_req(24'h100001 + 24'(i), 16'(i), 1'b0, 1'b1);
            checks++;
            if (BUS_RDY !== (i < DEPTH - 1) || COUNT !== 4'(i + 1) || OVERFLOW !== 1'b0) begin
                failures++;
                $display("FAIL fill_%0d: rdy/count/ovf %b/%0d/%b required %b/%0d/0",
                         i, BUS_RDY, COUNT, OVERFLOW, (i < DEPTH - 1), i + 1);
            end
        end
        push_req(24'h1000FF, 16'h00EE, 1'b0, 1'b0);
        checks++;
        if (OVERFLOW !== 1'b1 || COUNT !== 4'd8) begin
            failures++;
            $display("FAIL drop: ovf/count %b/%0d required 1/8", OVERFLOW, COUNT);
        end
        OVF_CLR = 1'b1;
        push_req(24'h1000FE, 16'h00ED, 1'b0, 1'b0);
        OVF_CLR = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b1 || COUNT !== 4'd8) begin
            failures++;
            $display("FAIL set_wins: ovf/count %b/%0d required 1/8", OVERFLOW, COUNT);
        end
        OVF_CLR = 1'b1;
        tick();
        OVF_CLR = 1'b0;
        checks++;
        if (OVERFLOW !== 1'b0 || COUNT !== 4'd8 || BUS_RDY !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clr: ovf/count/rdy %b/%0d/%b required 0/8/0", OVERFLOW, COUNT, BUS_RDY);
        end
    endtask

    task automatic test_full_pop;
        SRAM_ACK = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_req(24'h200000 + 24'(i), 16'(8'hA0 + i), 1'b0, 1'b1);
            checks++;
            if (COUNT !== 4'd8 || OVERFLOW !== 1'b0 || BUS_RDY !== 1'b0) begin
                failures++;
                $display("FAIL full_pop_%0d: count/ovf/rdy %0d/%b/%b required 8/0/0",
                         i, COUNT, OVERFLOW, BUS_RDY);
            end
        end
        drain();
    endtask

    task automatic test_reset_mid_word;
        SRAM_ACK = 1'b0;
        push_req(24'h300000, 16'hA1B2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) push_req(24'h300010 + 24'(i), 16'(i), 1'b0, 1'b0);
        wait_req();
        SRAM_ACK = 1'b1;
        tick();
        SRAM_ACK = 1'b0;
        checks++;
        if (SRAM_REQ !== 1'b1 || SRAM_ADDR !== 24'h300001 || SRAM_DATA !== 8'hA1 || COUNT !== 4'd3) begin
            failures++;
            $display("FAIL mid_hi: req/addr/data/count %b/%h/%h/%0d required 1/300001/a1/3",
                     SRAM_REQ, SRAM_ADDR, SRAM_DATA, COUNT);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (SRAM_REQ !== 1'b0 || COUNT !== 4'd0 || BUS_RDY !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: req/count/rdy %b/%0d/%b required 0/0/1", SRAM_REQ, COUNT, BUS_RDY);
        end
        exp_q.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        SRAM_ACK = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (SRAM_REQ !== 1'b0) begin
                failures++;
                $display("FAIL post_reset_%0d: SRAM_REQ=%b required 0", i, SRAM_REQ);
            end
        end
        push_req(24'h400000, 16'h0077, 1'b0, 1'b1);
        drain();
    endtask

    // Requests are issued only while fewer than DEPTH bytes are outstanding, so
    // nothing can be dropped and every byte must come out in issue order.
    task automatic test_random;
        logic [23:0] a;
        for (int i = 0; i < 400; i++) begin
            SRAM_ACK = 1'($urandom_range(0, 1));
            if (exp_q.size() < DEPTH && $urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
                push_req(a, 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            end else begin
                tick();
            end
        end
        drain();
        checks++;
        if (COUNT !== 4'd0 || OVERFLOW !== 1'b0) begin
            failures++;
            $display("FAIL random_end: count/ovf %0d/%b required 0/0", COUNT, OVERFLOW);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_word_split();
        test_addr_wrap();
        test_overflow();
        test_full_pop();
        test_reset_mid_word();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
